// File: rtl/lcd_win_proc.sv
// lcd_win_proc
//   Loads a W x H image (W = 2**XW, H = 2**YW) from the image ROM into an
//   internal pixel buffer. It then runs host commands on a 2x2 window whose
//   bottom-right pixel is the op point (px,py). Command 0 streams the buffer
//   out to the image RAM and pulses done.
//
//   Optional build macro: LCD_ROUND_AVG_EN. When it is defined, the average
//   command rounds half up ((sum+2)>>2). Otherwise it truncates (sum>>2).
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset; restarts the ROM load
//   cmd        command code (0 write, 1-4 shift, 5-B window ops, C-F no-op)
//   cmd_valid  command qualifier, only honoured while busy is low
//   rom_q      ROM read data, valid the cycle after rom_a
//   rom_rd     ROM read enable
//   rom_a      ROM address, row-major (y*W + x)
//   ram_valid  RAM write strobe
//   ram_d      RAM write data
//   ram_a      RAM write address
//   busy       high while loading or executing
//   done       one-cycle pulse when the write-back completes
module lcd_win_proc #(
    parameter int DW = 8,
    parameter int XW = 3,
    parameter int YW = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       cmd,
    input  logic             cmd_valid,
    input  logic [DW-1:0]    rom_q,
    output logic             rom_rd,
    output logic [XW+YW-1:0] rom_a,
    output logic             ram_valid,
    output logic [DW-1:0]    ram_d,
    output logic [XW+YW-1:0] ram_a,
    output logic             busy,
    output logic             done
);
    localparam int W  = 2**XW;
    localparam int H  = 2**YW;
    localparam int N  = W * H;
    localparam int AW = XW + YW;

    typedef enum logic [1:0] {LOAD, IDLE, EXEC, WRITE} state_t;

    state_t         state_q;
    logic [XW-1:0]  px_q;
    logic [YW-1:0]  py_q;
    logic [3:0]     cmd_q;
    logic           phase_q;      // window ops: 0 = sample, 1 = write
    logic           rom_rd_q, ld_fin_q;
    logic [AW-1:0]  rom_a_q;
    logic           cap_vld_q;    // rom_q holds data for cap_a_q this cycle
    logic [AW-1:0]  cap_a_q;
    logic           ram_valid_q, done_q, busy_q;
    logic [DW-1:0]  ram_d_q;
    logic [AW-1:0]  ram_a_q;
    logic [DW-1:0]  s_tl_q, s_tr_q, s_bl_q, s_br_q;

    logic [DW-1:0]  mem [N];

    logic [AW-1:0]  a_tl, a_tr, a_bl, a_br;
    logic [DW-1:0]  tl_d, tr_d, bl_d, br_d;
    logic [DW-1:0]  mx, mn, avg;
    logic [DW+1:0]  sum;
    logic           is_win, win_we;

    // Row-major addressing: {y, x} equals y*W + x because W is a power of two.
    assign a_tl = {py_q - YW'(1), px_q - XW'(1)};
    assign a_tr = {py_q - YW'(1), px_q};
    assign a_bl = {py_q,          px_q - XW'(1)};
    assign a_br = {py_q,          px_q};

    assign is_win = (cmd_q >= 4'h5) && (cmd_q <= 4'hB);
    assign win_we = (state_q == EXEC) && phase_q && is_win;

    // Window results come from the sampled pre-command values, so all four
    // writes land together and none of them sees another's result.
    always_comb begin
        mx = s_tl_q;
        if (s_tr_q > mx) mx = s_tr_q;
        if (s_bl_q > mx) mx = s_bl_q;
        if (s_br_q > mx) mx = s_br_q;
        mn = s_tl_q;
        if (s_tr_q < mn) mn = s_tr_q;
        if (s_bl_q < mn) mn = s_bl_q;
        if (s_br_q < mn) mn = s_br_q;
        sum = {2'b00, s_tl_q} + {2'b00, s_tr_q} + {2'b00, s_bl_q} + {2'b00, s_br_q};
`ifdef LCD_ROUND_AVG_EN
        avg = DW'((sum + (DW+2)'(2)) >> 2);
`else
        avg = DW'(sum >> 2);
`endif
        tl_d = s_tl_q; tr_d = s_tr_q; bl_d = s_bl_q; br_d = s_br_q;
        case (cmd_q)
            4'h5: begin tl_d = mx;  tr_d = mx;  bl_d = mx;  br_d = mx;  end
            4'h6: begin tl_d = mn;  tr_d = mn;  bl_d = mn;  br_d = mn;  end
            4'h7: begin tl_d = avg; tr_d = avg; bl_d = avg; br_d = avg; end
            4'h8: begin tl_d = s_tr_q; tr_d = s_br_q; br_d = s_bl_q; bl_d = s_tl_q; end
            4'h9: begin tl_d = s_bl_q; bl_d = s_br_q; br_d = s_tr_q; tr_d = s_tl_q; end
            4'hA: begin tl_d = s_bl_q; bl_d = s_tl_q; tr_d = s_br_q; br_d = s_tr_q; end
            4'hB: begin tl_d = s_tr_q; tr_d = s_tl_q; bl_d = s_br_q; br_d = s_bl_q; end
            default: ;
        endcase
    end

    // Pixel buffer: no reset, a reload overwrites it completely.
    always_ff @(posedge clk) begin
        if (cap_vld_q) mem[cap_a_q] <= rom_q;
        if (win_we) begin
            mem[a_tl] <= tl_d;
            mem[a_tr] <= tr_d;
            mem[a_bl] <= bl_d;
            mem[a_br] <= br_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD;
            px_q        <= XW'(W/2);
            py_q        <= YW'(H/2);
            cmd_q       <= '0;
            phase_q     <= 1'b0;
            rom_rd_q    <= 1'b0;
            rom_a_q     <= '0;
            ld_fin_q    <= 1'b0;
            cap_vld_q   <= 1'b0;
            cap_a_q     <= '0;
            ram_valid_q <= 1'b0;
            ram_d_q     <= '0;
            ram_a_q     <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
            s_tl_q      <= '0;
            s_tr_q      <= '0;
            s_bl_q      <= '0;
            s_br_q      <= '0;
        end else begin
            done_q    <= 1'b0;
            // The ROM samples rom_a on this edge, so its data is captured on the next one.
            cap_vld_q <= rom_rd_q;
            cap_a_q   <= rom_a_q;
            case (state_q)
                LOAD: begin
                    if (!ld_fin_q) begin
                        rom_rd_q <= 1'b1;
                        if (rom_rd_q) begin
                            if (rom_a_q == AW'(N-1)) begin
                                rom_rd_q <= 1'b0;
                                ld_fin_q <= 1'b1;
                            end else begin
                                rom_a_q <= rom_a_q + AW'(1);
                            end
                        end
                    end else if (cap_vld_q) begin
                        // This edge captures the final pixel.
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (cmd_valid && !busy_q) begin
                        cmd_q   <= cmd;
                        busy_q  <= 1'b1;
                        phase_q <= 1'b0;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (cmd_q == 4'h0) begin
                        ram_valid_q <= 1'b1;
                        ram_a_q     <= '0;
                        ram_d_q     <= mem[0];
                        state_q     <= WRITE;
                    end else if (is_win && !phase_q) begin
                        phase_q <= 1'b1;
                        s_tl_q  <= mem[a_tl];
                        s_tr_q  <= mem[a_tr];
                        s_bl_q  <= mem[a_bl];
                        s_br_q  <= mem[a_br];
                    end else begin
                        case (cmd_q)
                            4'h1: if (py_q != YW'(1))   py_q <= py_q - YW'(1);
                            4'h2: if (py_q != YW'(H-1)) py_q <= py_q + YW'(1);
                            4'h3: if (px_q != XW'(1))   px_q <= px_q - XW'(1);
                            4'h4: if (px_q != XW'(W-1)) px_q <= px_q + XW'(1);
                            default: ;
                        endcase
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                WRITE: begin
                    if (ram_a_q == AW'(N-1)) begin
                        ram_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        ram_a_q <= ram_a_q + AW'(1);
                        ram_d_q <= mem[ram_a_q + AW'(1)];
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign rom_rd    = rom_rd_q;
    assign rom_a     = rom_a_q;
    assign ram_valid = ram_valid_q;
    assign ram_d     = ram_d_q;
    assign ram_a     = ram_a_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_lcd_win_proc.sv
// Testbench for lcd_win_proc: W=H=8, DW=8. A reference image model is kept
// as a plain int array together with the op point.
module tb_lcd_win_proc;
    localparam int DW = 8, XW = 3, YW = 3;
    localparam int W = 1 << XW, H = 1 << YW, N = W * H;
`ifdef LCD_ROUND_AVG_EN
    localparam int RND = 2;
`else
    localparam int RND = 0;
`endif

    logic             clk, reset;
    logic [3:0]       cmd;
    logic             cmd_valid;
    logic [DW-1:0]    rom_q;
    logic             rom_rd;
    logic [XW+YW-1:0] rom_a;
    logic             ram_valid;
    logic [DW-1:0]    ram_d;
    logic [XW+YW-1:0] ram_a;
    logic             busy, done;

    int checks = 0, errors = 0;
    logic [DW-1:0] rom [N];
    int img [N];
    int ram [N];
    int mx, my;

    lcd_win_proc #(.DW(DW), .XW(XW), .YW(YW)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .rom_q(rom_q), .rom_rd(rom_rd), .rom_a(rom_a),
        .ram_valid(ram_valid), .ram_d(ram_d), .ram_a(ram_a),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read ROM: data appears the cycle after the address.
    always @(posedge clk) if (rom_rd) rom_q <= rom[rom_a];

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic void model_reload();
        for (int i = 0; i < N; i++) img[i] = rom[i];
        mx = W / 2;
        my = H / 2;
    endfunction

    // Window order in a[], v[] and n[]: TL, TR, BL, BR.
    function automatic void model_cmd(int c);
        int a[4];
        int v[4];
        int n[4];
        int s;
        a[0] = (my-1)*W + mx-1; a[1] = (my-1)*W + mx;
        a[2] = my*W + mx-1;     a[3] = my*W + mx;
        for (int i = 0; i < 4; i++) v[i] = img[a[i]];
        n = v;
        case (c)
            1: my = clampi(my-1, 1, H-1);
            2: my = clampi(my+1, 1, H-1);
            3: mx = clampi(mx-1, 1, W-1);
            4: mx = clampi(mx+1, 1, W-1);
            5: begin s = v[0]; for (int i = 1; i < 4; i++) if (v[i] > s) s = v[i]; n = '{s, s, s, s}; end
            6: begin s = v[0]; for (int i = 1; i < 4; i++) if (v[i] < s) s = v[i]; n = '{s, s, s, s}; end
            7: begin s = (v[0] + v[1] + v[2] + v[3] + RND) / 4; n = '{s, s, s, s}; end
            8: n = '{v[1], v[3], v[0], v[2]};
            9: n = '{v[2], v[0], v[3], v[1]};
            10: n = '{v[2], v[3], v[0], v[1]};
            11: n = '{v[1], v[0], v[3], v[2]};
            default: ;
        endcase
        for (int i = 0; i < 4; i++) img[a[i]] = n[i];
    endfunction

    function automatic int first_diff();
        for (int i = 0; i < N; i++) if (ram[i] != img[i]) return i;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 1000) begin step(); t++; end
    endtask

    // Returns the number of edges after the first un-reset edge until busy is low.
    task automatic do_reset_load(output int cyc);
        reset = 1'b1; cmd_valid = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        cyc = 0;
        while (busy && cyc < 1000) begin step(); cyc++; end
        model_reload();
    endtask

    task automatic send_cmd(input int c, output int bcyc);
        wait_idle();
        cmd = 4'(c); cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        bcyc = 0;
        while (busy && bcyc < 1000) begin step(); bcyc++; end
        model_cmd(c);
    endtask

    task automatic write_back(output int nb, output bit order_ok, output bit done_ok);
        int t = 0;
        for (int i = 0; i < N; i++) ram[i] = -1;
        nb = 0; order_ok = 1'b1; done_ok = 1'b0;
        wait_idle();
        cmd = 4'h0; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        while (t < N + 20) begin
            if (ram_valid) begin
                if (int'(ram_a) != nb) order_ok = 1'b0;
                ram[ram_a] = int'(ram_d);
                nb++;
            end else if (nb > 0) begin
                done_ok = (done === 1'b1) && (busy === 1'b0);
                step();
                if (done !== 1'b0) done_ok = 1'b0;
                break;
            end
            step();
            t++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd = 4'h5; cmd_valid = 1'b1;
        step(); step(); step();
        cmd_valid = 1'b0;
        checks++;
        if ({busy, done, rom_rd, rom_a, ram_valid, ram_d, ram_a} !==
            {1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 8'd0, 6'd0}) begin
            errors++;
            $display("FAIL reset_values: got %h want %h",
                     {busy, done, rom_rd, rom_a, ram_valid, ram_d, ram_a},
                     {1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 8'd0, 6'd0});
        end
    endtask

    task automatic test_load();
        int cyc, nb, d;
        bit ord, dok;
        for (int i = 0; i < N; i++) rom[i] = DW'(i);
        do_reset_load(cyc);
        checks++;
        if (cyc != N + 1) begin errors++; $display("FAIL load_latency: got %0d want %0d", cyc, N + 1); end
        write_back(nb, ord, dok);
        checks++;
        if (nb != N) begin errors++; $display("FAIL load_beats: got %0d want %0d", nb, N); end
        checks++;
        if (!ord) begin errors++; $display("FAIL load_addr_order: got 0 want 1"); end
        checks++;
        if (!dok) begin errors++; $display("FAIL load_done_pulse: got 0 want 1"); end
        d = first_diff();
        checks++;
        if (d >= 0) begin errors++; $display("FAIL load_image: addr %0d got %0d want %0d", d, ram[d], img[d]); end
    endtask

    task automatic test_max();
        int cyc, b, nb, d;
        bit ord, dok;
        do_reset_load(cyc);
        send_cmd(5, b);
        checks++;
        if (b != 2) begin errors++; $display("FAIL max_busy: got %0d want 2", b); end
        write_back(nb, ord, dok);
        checks++;
        if (ram[27] != 36 || ram[28] != 36 || ram[35] != 36 || ram[36] != 36) begin
            errors++;
            $display("FAIL max_window: got %0d %0d %0d %0d want 36", ram[27], ram[28], ram[35], ram[36]);
        end
        d = first_diff();
        checks++;
        if (d >= 0) begin errors++; $display("FAIL max_image: addr %0d got %0d want %0d", d, ram[d], img[d]); end
    endtask

    task automatic test_avg();
        int cyc, b, nb, d, exp_v;
        bit ord, dok;
        exp_v = (RND != 0) ? 32 : 31;
        do_reset_load(cyc);
        send_cmd(7, b);
        write_back(nb, ord, dok);
        checks++;
        if (ram[27] != exp_v || ram[28] != exp_v || ram[35] != exp_v || ram[36] != exp_v) begin
            errors++;
            $display("FAIL avg_window: got %0d %0d %0d %0d want %0d", ram[27], ram[28], ram[35], ram[36], exp_v);
        end
        d = first_diff();
        checks++;
        if (d >= 0) begin errors++; $display("FAIL avg_image: addr %0d got %0d want %0d", d, ram[d], img[d]); end
        for (int i = 0; i < N; i++) rom[i] = '1;
        do_reset_load(cyc);
        send_cmd(7, b);
        write_back(nb, ord, dok);
        checks++;
        if (ram[27] != 255 || ram[28] != 255 || ram[35] != 255 || ram[36] != 255) begin
            errors++;
            $display("FAIL avg_saturate: got %0d %0d %0d %0d want 255", ram[27], ram[28], ram[35], ram[36]);
        end
    endtask

    task automatic test_clamp_rotate();
        int cyc, b, nb, d, bad;
        bit ord, dok;
        for (int i = 0; i < N; i++) rom[i] = DW'(i);
        do_reset_load(cyc);
        bad = 0;
        for (int i = 0; i < 5; i++) begin send_cmd(1, b); if (b != 1) bad++; end
        for (int i = 0; i < 5; i++) begin send_cmd(3, b); if (b != 1) bad++; end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL shift_busy: got %0d wrong lengths want 0", bad); end
        send_cmd(9, b);
        write_back(nb, ord, dok);
        checks++;
        if (ram[0] != 8 || ram[1] != 0 || ram[8] != 9 || ram[9] != 1) begin
            errors++;
            $display("FAIL clamp_rotate: got %0d %0d %0d %0d want 8 0 9 1", ram[0], ram[1], ram[8], ram[9]);
        end
        d = first_diff();
        checks++;
        if (d >= 0) begin errors++; $display("FAIL rotate_image: addr %0d got %0d want %0d", d, ram[d], img[d]); end
    endtask

    task automatic test_mirror_handshake();
        int cyc, nb, d, t;
        bit ord, dok;
        do_reset_load(cyc);
        cmd = 4'hB; cmd_valid = 1'b1;
        step();
        // Extra request while busy must be dropped.
        cmd = 4'h5;
        step();
        cmd_valid = 1'b0;
        t = 0;
        while (busy && t < 100) begin step(); t++; end
        model_cmd(11);
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ignored_cmd_busy: got %b want 0", busy); end
        write_back(nb, ord, dok);
        checks++;
        if (ram[27] != 28 || ram[28] != 27 || ram[35] != 36 || ram[36] != 35) begin
            errors++;
            $display("FAIL mirror_y: got %0d %0d %0d %0d want 28 27 36 35", ram[27], ram[28], ram[35], ram[36]);
        end
        d = first_diff();
        checks++;
        if (d >= 0) begin errors++; $display("FAIL mirror_image: addr %0d got %0d want %0d", d, ram[d], img[d]); end
    endtask

    task automatic test_random();
        int cyc, b, nb, d, bad, c;
        bit ord, dok;
        for (int i = 0; i < N; i++) rom[i] = DW'($urandom);
        do_reset_load(cyc);
        for (int pass = 0; pass < 2; pass++) begin
            bad = 0;
            for (int k = 0; k < 40; k++) begin
                c = int'($urandom_range(1, 15));
                send_cmd(c, b);
                if (b != ((c >= 5 && c <= 11) ? 2 : 1)) bad++;
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL random_busy: got %0d wrong lengths want 0", bad); end
            write_back(nb, ord, dok);
            d = first_diff();
            checks++;
            if (d >= 0 || !dok) begin
                errors++;
                $display("FAIL random_image: addr %0d done %0b got %0d want %0d", d, dok,
                         (d >= 0) ? ram[d] : 0, (d >= 0) ? img[d] : 0);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int t, nb, d;
        bit ord, dok;
        wait_idle();
        cmd = 4'h0; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        t = 0;
        while (!(ram_valid && ram_a == 6'd20) && t < 200) begin step(); t++; end
        checks++;
        if (t >= 200) begin errors++; $display("FAIL midwrite_beat20: got timeout want beat 20"); end
        reset = 1'b1;
        step();
        checks++;
        if (ram_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midwrite_reset: got valid %b busy %b want 0 1", ram_valid, busy);
        end
        reset = 1'b0;
        step();
        checks++;
        if (rom_rd !== 1'b1 || rom_a !== 6'd0) begin
            errors++;
            $display("FAIL reload_start: got rd %b addr %0d want 1 0", rom_rd, rom_a);
        end
        t = 0;
        while (busy && t < 1000) begin step(); t++; end
        model_reload();
        write_back(nb, ord, dok);
        d = first_diff();
        checks++;
        if (d >= 0 || nb != N) begin
            errors++;
            $display("FAIL reload_image: addr %0d beats %0d got %0d want %0d", d, nb,
                     (d >= 0) ? ram[d] : 0, (d >= 0) ? img[d] : 0);
        end
    endtask

    initial begin
        reset = 1'b1; cmd = 4'h0; cmd_valid = 1'b0;
        test_reset();
        test_load();
        test_max();
        test_avg();
        test_clamp_rotate();
        test_mirror_handshake();
        test_random();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
